segment_scan_driver: RTL and testbench

//  Time-multiplexed driver for a DIGITS-wide common-anode 7-segment bank. It decodes 5-bit glyph codes
//  (0-F, L, n, P, blank) plus per-digit decimal points. Writes are double-buffered so the display never

---
 rtl/segment_scan_driver_if.sv | 24 ++
 rtl/segment_scan_driver.sv | 169 ++++++++++++++++
 tb/tb_segment_scan_driver.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/segment_scan_driver_if.sv
// Bus between a controller and the 7-segment scan driver.
// The master writes codes and control; the slave drives the display lines.
interface segment_scan_driver_if #(
   parameter int DIGITS = 4
);
   logic                  enable;
   logic                  load;
   logic [5*DIGITS-1:0]   codes;
   logic [DIGITS-1:0]     dp;
   logic                  lz_blank;
   logic [7:0]            segments;
   logic [DIGITS-1:0]     digit_sel;
   logic                  frame_tick;

   modport master (
      output enable, load, codes, dp, lz_blank,
      input  segments, digit_sel, frame_tick
   );

   modport slave (
      input  enable, load, codes, dp, lz_blank,
      output segments, digit_sel, frame_tick
   );
endinterface

// File: rtl/segment_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a double-buffered code
// bank, a blanking guard at the start of every digit slot, and optional
// leading-zero suppression. All display outputs come straight from flops.
module segment_scan_driver #(
   parameter int DIGITS       = 4,
   parameter int PRESCALE     = 1024,
   parameter int BLANK_CYCLES = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   segment_scan_driver_if.slave bus
);
   localparam int CW = $clog2(PRESCALE);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

   state_t              state_reg, state_next;
   logic [CW-1:0]       cnt_reg, cnt_next;
   logic [IW-1:0]       idx_reg, idx_next;
   logic                frame_last;
   logic                swap_ok;

   logic [5*DIGITS-1:0] active_codes_reg, shadow_codes_reg;
   logic [DIGITS-1:0]   active_dp_reg, shadow_dp_reg;
   logic                pending_reg;

   logic [7:0]          segments_reg, segments_next;
   logic [DIGITS-1:0]   digit_sel_reg, digit_sel_next;
   logic                frame_tick_reg, frame_tick_next;

   logic                lead_zero;
   logic [DIGITS-1:0]   suppress;
   logic [7:0]          pattern [DIGITS];

   // Glyph table, active-high, bit0 (dp) left clear.
   function automatic logic [7:0] glyph(input logic [4:0] code);
      case (code)
         5'h00: glyph = 8'h7E;  5'h01: glyph = 8'h0C;
         5'h02: glyph = 8'hB6;  5'h03: glyph = 8'h9E;
         5'h04: glyph = 8'hCC;  5'h05: glyph = 8'hDA;
         5'h06: glyph = 8'hFA;  5'h07: glyph = 8'h0E;
         5'h08: glyph = 8'hFE;  5'h09: glyph = 8'hCE;
         5'h0A: glyph = 8'hEE;  5'h0B: glyph = 8'hF8;
         5'h0C: glyph = 8'h72;  5'h0D: glyph = 8'hBC;
         5'h0E: glyph = 8'hF2;  5'h0F: glyph = 8'hE2;
         5'h10: glyph = 8'h70;  5'h11: glyph = 8'hA8;
         5'h12: glyph = 8'hE6;
         default: glyph = 8'h00;
      endcase
   endfunction

   // Leading-zero mask: walk from the leftmost digit while codes are zero; digit 0 always shows.
   always_comb begin
      lead_zero = 1'b1;
      suppress  = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         lead_zero = lead_zero & (active_codes_reg[5*i +: 5] == 5'h00);
         if (i != 0) suppress[i] = bus.lz_blank & lead_zero;
      end
   end

   // Per-digit active-high pattern; a suppressed digit keeps only its decimal point.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign pattern[gi] = suppress[gi] ? {7'b0, active_dp_reg[gi]}
                         : (glyph(active_codes_reg[5*gi +: 5]) | {7'b0, active_dp_reg[gi]});
   end

   assign frame_last = (state_reg == ON) && (cnt_reg == CNT_LAST) && (idx_reg == IDX_LAST);
   // The shadow bank may only move into the active bank at a frame boundary or while dark.
   assign swap_ok    = frame_last || (state_reg == IDLE);

   // Scan sequencer: next state, slot counter and digit index.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      if (!bus.enable) begin
         state_next = IDLE;
         cnt_next   = '0;
         idx_next   = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               state_next = BLANK;
               cnt_next   = '0;
               idx_next   = '0;
            end
            BLANK: begin
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == BLANK_LAST) state_next = ON;
            end
            ON: begin
               if (cnt_reg == CNT_LAST) begin
                  cnt_next   = '0;
                  state_next = BLANK;
                  idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
               idx_next   = '0;
            end
         endcase
      end
   end

   // Output values for the upcoming state, so the registered outputs line up with it.
   always_comb begin
      segments_next   = 8'hFF;
      digit_sel_next  = '1;
      frame_tick_next = 1'b0;
      if (state_next == ON) begin
         digit_sel_next  = ~(DIGITS'(1) << idx_next);
         segments_next   = ~pattern[idx_next];
         frame_tick_next = (cnt_next == CNT_LAST) && (idx_next == IDX_LAST);
      end
   end

   // Sequencer and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= BLANK;
         cnt_reg        <= '0;
         idx_reg        <= '0;
         segments_reg   <= 8'hFF;
         digit_sel_reg  <= '1;
         frame_tick_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         idx_reg        <= idx_next;
         segments_reg   <= segments_next;
         digit_sel_reg  <= digit_sel_next;
         frame_tick_reg <= frame_tick_next;
      end
   end

   // Double buffer: load fills the shadow, swap moves the old shadow to active.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_codes_reg <= {DIGITS{5'h1F}};
         shadow_codes_reg <= {DIGITS{5'h1F}};
         active_dp_reg    <= '0;
         shadow_dp_reg    <= '0;
         pending_reg      <= 1'b0;
      end else begin
         if (bus.load) begin
            shadow_codes_reg <= bus.codes;
            shadow_dp_reg    <= bus.dp;
         end
         if (swap_ok && pending_reg) begin
            active_codes_reg <= shadow_codes_reg;
            active_dp_reg    <= shadow_dp_reg;
         end
         pending_reg <= bus.load | (pending_reg & ~swap_ok);
      end
   end

   assign bus.segments   = segments_reg;
   assign bus.digit_sel  = digit_sel_reg;
   assign bus.frame_tick = frame_tick_reg;
endmodule

// File: tb/tb_segment_scan_driver.sv
// Bench for segment_scan_driver with a 4-digit, 8-cycle-slot, 2-cycle-guard setup.
// Expected digit slots are queued at load time and popped as slots appear.
module tb_segment_scan_driver;
   localparam int DIGITS = 4;

   logic clk;
   logic rst_n;

   segment_scan_driver_if #(.DIGITS(DIGITS)) bus ();

   segment_scan_driver #(
      .DIGITS(DIGITS),
      .PRESCALE(8),
      .BLANK_CYCLES(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] codes;
      logic [3:0]  dp;
      logic        lz;
      logic [31:0] seg;   // {digit3, digit2, digit1, digit0}, active-low
   } vec_t;

   typedef struct packed {
      logic [3:0] sel;
      logic [7:0] seg;
   } exp_t;

   vec_t vecs [9];
   exp_t exp_q [$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out, expected event", name);
   endtask

   // Called at a negedge; load is seen by the following rising edge.
   task automatic do_load(input logic [19:0] c, input logic [3:0] d);
      bus.codes = c;
      bus.dp    = d;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.load  = 1'b0;
   endtask

   task automatic push_exp(input logic [31:0] seg);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         e.sel = ~(4'b0001 << i);
         e.seg = seg[8*i +: 8];
         exp_q.push_back(e);
      end
   endtask

   // Returns at the negedge on which frame_tick is high (always advances first).
   task automatic wait_tick();
      int n;
      n = 0;
      @(negedge clk);
      while (bus.frame_tick !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) timeout_fail("wait frame_tick");
   endtask

   // Returns at the first negedge of the next digit slot's lit phase.
   task automatic next_entry(output logic [3:0] sel, output logic [7:0] seg);
      logic [3:0] prev;
      int n;
      prev = bus.digit_sel;
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (bus.digit_sel !== 4'hF && prev === 4'hF) break;
         if (n >= 40) begin
            timeout_fail("wait digit slot");
            break;
         end
         prev = bus.digit_sel;
      end
      sel = bus.digit_sel;
      seg = bus.segments;
   endtask

   task automatic capture_frame();
      logic [3:0] sel;
      logic [7:0] seg;
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         next_entry(sel, seg);
         if (exp_q.size() == 0) begin
            timeout_fail("scoreboard empty");
         end else begin
            e = exp_q.pop_front();
            check($sformatf("slot%0d digit_sel", k), 32'(sel), 32'(e.sel));
            check($sformatf("slot%0d segments", k), 32'(seg), 32'(e.seg));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] sel;
      logic [7:0] seg;
      int n;

      vecs[0] = '{codes: {5'h03, 5'h02, 5'h01, 5'h00}, dp: 4'b0000, lz: 1'b0, seg: 32'h6149F381};
      vecs[1] = '{codes: {5'h09, 5'h09, 5'h09, 5'h09}, dp: 4'b0000, lz: 1'b0, seg: 32'h31313131};
      vecs[2] = '{codes: {5'h00, 5'h00, 5'h05, 5'h00}, dp: 4'b0000, lz: 1'b1, seg: 32'hFFFF2581};
      vecs[3] = '{codes: {5'h08, 5'h08, 5'h08, 5'h08}, dp: 4'b0010, lz: 1'b0, seg: 32'h01010001};
      vecs[4] = '{codes: {5'h10, 5'h11, 5'h12, 5'h13}, dp: 4'b1000, lz: 1'b0, seg: 32'h8E5719FF};
      vecs[5] = '{codes: {5'h00, 5'h00, 5'h00, 5'h00}, dp: 4'b0100, lz: 1'b1, seg: 32'hFFFEFF81};
      vecs[6] = '{codes: {5'h00, 5'h07, 5'h00, 5'h00}, dp: 4'b0000, lz: 1'b1, seg: 32'hFFF18181};
      vecs[7] = '{codes: {5'h0A, 5'h0B, 5'h0C, 5'h0D}, dp: 4'b0000, lz: 1'b0, seg: 32'h11078D43};
      vecs[8] = '{codes: {5'h0E, 5'h0F, 5'h04, 5'h06}, dp: 4'b0000, lz: 1'b0, seg: 32'h0D1D3305};

      rst_n        = 1'b1;
      bus.enable   = 1'b1;
      bus.load     = 1'b0;
      bus.codes    = '0;
      bus.dp       = '0;
      bus.lz_blank = 1'b0;
      #1 rst_n = 1'b0;

      // Reset state and the default (blank) bank.
      repeat (3) @(negedge clk);
      check("reset segments", 32'(bus.segments), 32'hFF);
      check("reset digit_sel", 32'(bus.digit_sel), 32'hF);
      check("reset frame_tick", 32'(bus.frame_tick), 32'h0);
      rst_n = 1'b1;
      next_entry(sel, seg);
      check("first slot digit_sel", 32'(sel), 32'hE);
      check("first slot segments", 32'(seg), 32'hFF);

      // Slot timing: 6 lit cycles, 2 guard cycles, next digit.
      n = 0;
      while (bus.digit_sel === 4'hE && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("lit cycles", 32'(n), 32'd6);
      n = 0;
      while (bus.digit_sel === 4'hF && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("guard cycles", 32'(n), 32'd2);
      check("second slot digit_sel", 32'(bus.digit_sel), 32'hD);

      // Frame period and one-cycle tick.
      wait_tick();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.frame_tick !== 1'b1 && n < 100);
      check("frame period", 32'(n), 32'd32);
      @(negedge clk);
      check("tick width", 32'(bus.frame_tick), 32'h0);

      // Table of glyph/dp/suppression vectors.
      for (int v = 0; v < 9; v++) begin
         bus.lz_blank = vecs[v].lz;
         do_load(vecs[v].codes, vecs[v].dp);
         push_exp(vecs[v].seg);
         wait_tick();
         capture_frame();
      end
      bus.lz_blank = 1'b0;

      // Mid-frame load does not disturb the frame in progress.
      wait_tick();
      next_entry(sel, seg);
      next_entry(sel, seg);
      do_load({5'h09, 5'h09, 5'h09, 5'h09}, 4'b0000);
      push_exp(32'h31313131);
      next_entry(sel, seg);
      check("midload digit2 old", 32'(seg), 32'h1D);
      next_entry(sel, seg);
      check("midload digit3 old", 32'(seg), 32'h0D);
      wait_tick();
      capture_frame();

      // Load coinciding with the swap edge: old shadow goes active, new load waits a frame.
      do_load(vecs[7].codes, vecs[7].dp);
      push_exp(vecs[7].seg);
      wait_tick();
      do_load(vecs[0].codes, vecs[0].dp);
      push_exp(vecs[0].seg);
      capture_frame();
      wait_tick();
      capture_frame();

      // Disable mid-slot, load while dark, re-enable.
      bus.enable = 1'b0;
      @(posedge clk);
      #1;
      check("disable segments", 32'(bus.segments), 32'hFF);
      check("disable digit_sel", 32'(bus.digit_sel), 32'hF);
      check("disable frame_tick", 32'(bus.frame_tick), 32'h0);
      @(negedge clk);
      do_load({5'h01, 5'h01, 5'h01, 5'h07}, 4'b0000);
      repeat (2) @(negedge clk);
      bus.enable = 1'b1;
      @(negedge clk);
      check("reenable guard1", 32'(bus.digit_sel), 32'hF);
      @(negedge clk);
      check("reenable guard2", 32'(bus.digit_sel), 32'hF);
      @(negedge clk);
      check("reenable digit_sel", 32'(bus.digit_sel), 32'hE);
      check("reenable segments", 32'(bus.segments), 32'hF1);

      // Asynchronous reset in the middle of a lit slot.
      #3 rst_n = 1'b0;
      #1;
      check("async rst segments", 32'(bus.segments), 32'hFF);
      check("async rst digit_sel", 32'(bus.digit_sel), 32'hF);
      check("async rst frame_tick", 32'(bus.frame_tick), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      next_entry(sel, seg);
      check("post rst digit_sel", 32'(sel), 32'hE);
      check("post rst segments", 32'(seg), 32'hFF);

      if (exp_q.size() != 0) timeout_fail("scoreboard leftover");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
